// File: rtl/run_controller.sv
// run_controller: loads data RAM from a host stream, runs the core, then dumps the whole RAM.
// Define RUN_CTRL_WATCHDOG_EN to bound RUN at max_cycles and flag timeout.
module run_controller #(
  parameter int ram_size   = 32,
  parameter int load_words = 2,
  parameter int max_cycles = 1024,
  localparam int AW        = $clog2(ram_size)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [15:0]   ld_data,
  output logic          dmp_valid,
  input  logic          dmp_ready,
  output logic [15:0]   dmp_data,
  input  logic          cpu_ram_we,
  input  logic [AW-1:0] cpu_ram_addr,
  input  logic [15:0]   cpu_ram_wdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata,
  output logic          cpu_reset,
  input  logic          cpu_ended,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle_count
);
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit wd_en = 1'b1;
`else
  localparam bit wd_en = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE} state_t;
  state_t state, next;
  logic [AW-1:0] ld_ptr, dmp_ptr;
  logic [15:0] dmp_q;
  logic fresh, ld_fire, dmp_fire, dmp_last, restart, wd_hit;
  assign restart  = (state == IDLE || state == DONE) && start;
  assign ld_fire  = state == LOAD && ld_valid;
  assign dmp_fire = state == DUMP_OUT && dmp_ready;
  assign dmp_last = dmp_ptr == AW'(ram_size - 1);
  // true in the RUN cycle that brings the count up to max_cycles
  assign wd_hit   = wd_en && cycle_count >= 32'(max_cycles - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? LOAD : state;
      LOAD:       next = (ld_fire && ld_ptr == AW'(load_words - 1)) ? RUN : LOAD;
      RUN:        next = (cpu_ended || wd_hit) ? DUMP_RD : RUN;
      DUMP_RD:    next = DUMP_OUT;
      DUMP_OUT:   next = dmp_fire ? (dmp_last ? DONE : DUMP_RD) : DUMP_OUT;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      ld_ptr      <= '0;
      dmp_ptr     <= '0;
      dmp_q       <= '0;
      fresh       <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= next;
      fresh <= state == DUMP_RD;
      if (fresh)
        dmp_q <= ram_rdata;
      if (restart) begin
        ld_ptr      <= '0;
        dmp_ptr     <= '0;
        cycle_count <= '0;
        timeout     <= 1'b0;
      end
      if (ld_fire)
        ld_ptr <= ld_ptr + AW'(1);
      if (state == RUN && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (state == RUN && wd_hit && !cpu_ended)
        timeout <= 1'b1;
      if (dmp_fire && !dmp_last)
        dmp_ptr <= dmp_ptr + AW'(1);
    end
  assign ld_ready  = state == LOAD;
  assign ram_we    = ld_fire || (state == RUN && cpu_ram_we);
  assign ram_addr  = state == LOAD ? ld_ptr :
                     state == RUN ? cpu_ram_addr :
                     (state == DUMP_RD || state == DUMP_OUT) ? dmp_ptr : '0;
  assign ram_wdata = state == LOAD ? ld_data : state == RUN ? cpu_ram_wdata : '0;
  assign dmp_valid = state == DUMP_OUT;
  // first DUMP_OUT cycle passes the fresh read through; later cycles hold the captured copy
  assign dmp_data  = fresh ? ram_rdata : dmp_q;
  assign cpu_reset = state != RUN;
  assign busy      = state inside {LOAD, RUN, DUMP_RD, DUMP_OUT};
  assign done      = state == DONE;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: randomized load/run/dump scenarios checked every cycle against a behavioural model.
module tb_run_controller;
  localparam int RS = 32, LW = 2, MAXC = 20, AW = 5;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int CC1 = WD ? MAXC : 50;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_FETCH = 3, M_SHOW = 4, M_DONE = 5;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ld_valid = 1'b0, dmp_ready = 1'b0;
  logic [15:0] ld_data = '0, cpu_ram_wdata = '0;
  logic cpu_ram_we = 1'b0, cpu_ended = 1'b0;
  logic [AW-1:0] cpu_ram_addr = '0;
  logic ld_ready, dmp_valid, ram_we, cpu_reset, busy, done, timeout;
  logic [15:0] dmp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0] cycle_count;

  int checks = 0, errors = 0;
  int ld_mode = 0, rdy_mode = 0, end_at = 0, cpu_k = 0, wcnt = 0;
  bit fix_ld = 1'b0;
  logic [15:0] obs [$];

  run_controller #(.ram_size(RS), .load_words(LW), .max_cycles(MAXC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .dmp_valid(dmp_valid), .dmp_ready(dmp_ready), .dmp_data(dmp_data),
    .cpu_ram_we(cpu_ram_we), .cpu_ram_addr(cpu_ram_addr), .cpu_ram_wdata(cpu_ram_wdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_reset(cpu_reset), .cpu_ended(cpu_ended),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // data RAM: synchronous read, one cycle latency
  logic [15:0] mem [RS];
  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // reference model: what the RAM must hold and which phase the run is in
  int ph = M_IDLE, nld = 0, ndmp = 0;
  logic [31:0] m_cc = '0;
  logic m_to = 1'b0;
  logic [15:0] exp_mem [RS];
  wire [31:0] m_cc_next = (m_cc == 32'hFFFF_FFFF) ? m_cc : m_cc + 32'd1;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      ph <= M_IDLE; nld <= 0; ndmp <= 0; m_cc <= '0; m_to <= 1'b0;
    end else case (ph)
      M_IDLE, M_DONE: if (start) begin
        ph <= M_LOAD; nld <= 0; ndmp <= 0; m_cc <= '0; m_to <= 1'b0;
      end
      M_LOAD: if (ld_valid) begin
        exp_mem[nld] <= ld_data;
        nld <= nld + 1;
        if (nld == LW - 1) ph <= M_RUN;
      end
      M_RUN: begin
        if (cpu_ram_we) exp_mem[cpu_ram_addr] <= cpu_ram_wdata;
        m_cc <= m_cc_next;
        if (cpu_ended) ph <= M_FETCH;
        else if (WD && m_cc_next >= 32'(MAXC)) begin m_to <= 1'b1; ph <= M_FETCH; end
      end
      M_FETCH: ph <= M_SHOW;
      M_SHOW: if (dmp_ready) begin
        ndmp <= ndmp + 1;
        ph <= (ndmp == RS - 1) ? M_DONE : M_FETCH;
      end
      default: ph <= M_IDLE;
    endcase

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit e_we = (ph == M_LOAD && ld_valid) || (ph == M_RUN && cpu_ram_we);
    chk("ld_ready", ld_ready, ph == M_LOAD);
    chk("ram_we", ram_we, e_we);
    chk("cpu_reset", cpu_reset, ph != M_RUN);
    chk("busy", busy, ph inside {M_LOAD, M_RUN, M_FETCH, M_SHOW});
    chk("done_flag", done, ph == M_DONE);
    chk("dmp_valid", dmp_valid, ph == M_SHOW);
    chk("timeout_flag", timeout, m_to);
    chk("cycle_count", cycle_count, m_cc);
    if (e_we) chk("ram_wdata", ram_wdata, ph == M_LOAD ? ld_data : cpu_ram_wdata);
    if (ph == M_LOAD && ld_valid) chk("load_addr", ram_addr, nld);
    if (ph == M_RUN) chk("cpu_addr", ram_addr, cpu_ram_addr);
    if (ph == M_FETCH) chk("fetch_addr", ram_addr, ndmp);
    if (ph == M_SHOW) begin
      chk("dmp_data", dmp_data, exp_mem[ndmp]);
      if (dmp_ready) obs.push_back(dmp_data);
    end
    if (!reset) begin
      chk("rst_dmp_data", dmp_data, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
    end
  end

  // host stream drivers
  initial forever begin
    @(posedge clk); #2;
    ld_valid = ld_mode == 0 ? 1'b1 : ld_mode == 1 ? ~ld_valid : 1'($urandom_range(0, 2) != 0);
    ld_data = fix_ld ? (nld == 0 ? 16'd13 : 16'd8) : 16'($urandom);
    wcnt = dmp_valid ? wcnt + 1 : 0;
    dmp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (wcnt >= 4) : 1'($urandom_range(0, 1));
  end

  // core stand-in: writes 104 to addr 2 on its 6th cycle, scribbles on addr >= 3, ends on cycle end_at-1
  initial forever begin
    @(posedge clk); #2;
    if (cpu_reset) begin
      cpu_k = 0; cpu_ended = 1'b0; cpu_ram_we = 1'b0;
    end else begin
      cpu_ended = end_at != 0 && cpu_k == end_at - 1;
      cpu_ram_addr = AW'($urandom);
      cpu_ram_wdata = 16'($urandom);
      cpu_ram_we = 1'b0;
      if (cpu_k == 5) begin
        cpu_ram_we = 1'b1; cpu_ram_addr = 5'd2; cpu_ram_wdata = 16'd104;
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_ram_we = 1'b1; cpu_ram_addr = AW'(3 + $urandom_range(0, 28));
      end
      cpu_k++;
    end
  end

  task automatic reset_lits();
    chk("r_ld_ready", ld_ready, 0);   chk("r_dmp_valid", dmp_valid, 0);
    chk("r_dmp_data", dmp_data, 0);   chk("r_ram_we", ram_we, 0);
    chk("r_ram_addr", ram_addr, 0);   chk("r_ram_wdata", ram_wdata, 0);
    chk("r_cpu_reset", cpu_reset, 1); chk("r_busy", busy, 0);
    chk("r_done", done, 0);           chk("r_timeout", timeout, 0);
    chk("r_cycle_count", cycle_count, 0);
  endtask

  task automatic kick(input bit fixed, input int lm, input int rm, input int e);
    fix_ld = fixed; ld_mode = lm; rdy_mode = rm; end_at = e;
    obs.delete();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    chk("reached_done", done, 1);
  endtask

  task automatic wait_k(input int n);
    int t = 0;
    while (cpu_k != n && t < 500) begin @(negedge clk); t++; end
    chk("run_reached", cpu_k, n);
  endtask

  task automatic post_lits(input int cc);
    chk("dump_len", obs.size(), RS);
    if (obs.size() >= 3) begin
      chk("word0", obs[0], 13); chk("word1", obs[1], 8); chk("word2", obs[2], 104);
    end
    chk("cycles", cycle_count, cc);
    chk("timeout_end", timeout, WD);
    chk("done_end", done, 1);
  endtask

  initial begin
    int t;
    for (int i = 0; i < RS; i++) begin
      mem[i] <= 16'(i * 1237 + 91);
      exp_mem[i] <= 16'(i * 1237 + 91);
    end
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_lits();
    @(negedge clk); #1 reset = 1'b1;

    kick(1'b1, 0, 0, 50);
    wait_done();
    post_lits(CC1);

    // stalled streams, start pokes during LOAD and DUMP
    kick(1'b1, 1, 1, 50);
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    t = 0;
    while (!dmp_valid && t < 500) begin @(posedge clk); #2; t++; end
    chk("dump_started", dmp_valid, 1);
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done();
    post_lits(CC1);

    repeat (4) begin
      kick(1'b0, 2, 2, $urandom_range(7, 40));
      wait_done();
      chk("rand_dump_len", obs.size(), RS);
    end

    // asynchronous reset in the middle of RUN
    kick(1'b0, 0, 0, 0);
    wait_k(11);
    #1 reset = 1'b0;
    #1 reset_lits();
    @(negedge clk); #1 reset = 1'b1;
    kick(1'b0, 2, 2, 30);
    wait_done();
    chk("after_reset_len", obs.size(), RS);
    chk("after_reset_cycles", cycle_count, WD ? MAXC : 30);

`ifdef RUN_CTRL_WATCHDOG_EN
    kick(1'b0, 0, 2, 0);
    wait_done();
    chk("wd_timeout", timeout, 1);
    chk("wd_cycles", cycle_count, MAXC);
    chk("wd_dump_len", obs.size(), RS);
    kick(1'b0, 0, 0, MAXC);
    wait_done();
    chk("wd_tie_timeout", timeout, 0);
    chk("wd_tie_cycles", cycle_count, MAXC);
`else
    kick(1'b0, 0, 0, 0);
    wait_k(101);
    chk("hang_cycles", cycle_count, 100);
    chk("hang_busy", busy, 1);
    chk("hang_cpu_reset", cpu_reset, 0);
    chk("hang_dmp_valid", dmp_valid, 0);
    #1 reset = 1'b0;
    #1 reset_lits();
    @(negedge clk); #1 reset = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/run_controller.md
# run_controller

Sequencer and RAM-port arbiter wrapped around the `computer` core. It loads input words into data RAM from a host stream, holds the CPU in reset during loading, releases it and counts cycles until the core raises `ended`, then streams the whole RAM back out. It replaces file-based RAM init/dump with on-chip load/run/dump sequencing.

## Interface
- `ram_size`, 32: data RAM depth in 16-bit words; `AW = $clog2(ram_size)`.
- `load_words`, 2: words written at RAM addresses 0..load_words-1 per run; 1 ≤ load_words ≤ ram_size.
- `max_cycles`, 1024: watchdog limit on RUN cycles; only used with the watchdog compiled in.

- `clk`  in  1: clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low; 0 forces reset state immediately.
- `start`  in  1: begin a run; sampled in IDLE and DONE only.
- `ld_valid` / `ld_ready` / `ld_data`  in / out / in  1/1/16: load stream, transfer when both high.
- `dmp_valid` / `dmp_ready` / `dmp_data`  out / in / out  1/1/16: dump stream, word k = RAM[k].
- `cpu_ram_we`, `cpu_ram_addr`, `cpu_ram_wdata`  in  1/AW/16: CPU's RAM request.
- `ram_we`, `ram_addr`, `ram_wdata`  out  1/AW/16: arbitrated RAM port.
- `ram_rdata`  in  16: RAM read data, valid one cycle after `ram_addr`.
- `cpu_reset`  out  1: active-high reset to the core.
- `cpu_ended`  in  1: core halt flag.
- `busy`, `done`, `timeout`  out  1 each: status.
- `cycle_count`  out  32: RUN cycles of the last/current run.

## Operation
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE: `start`=1 → LOAD; load pointer, dump pointer, `cycle_count`, `timeout` cleared.
- LOAD: `ld_ready`=1; each handshake drives `ram_we`=1, `ram_addr`=load ptr, `ram_wdata`=`ld_data` combinationally in the same cycle; ptr++. Handshake on ptr = load_words-1 → RUN. `ld_valid` low = stall, no write.
- RUN: `cpu_reset`=0; RAM port muxed to `cpu_ram_*`; `cycle_count` +1 every RUN cycle. `cpu_ended`=1 sampled → DUMP_RD (that cycle still counted).
- DUMP_RD: `ram_we`=0, `ram_addr`=dump ptr → DUMP_OUT.
- DUMP_OUT: `dmp_data` registered from `ram_rdata` on entry, `dmp_valid`=1, held stable until `dmp_ready`. On handshake: ptr = ram_size-1 → DONE, else ptr++ → DUMP_RD.
- DONE: `done`=1 until `start`=1 → LOAD (same clears as IDLE).
- `cpu_reset`=1 in every state except RUN; controller owns the RAM port outside RUN; `ram_we`=0 whenever no write is legal.
- `busy`=1 in LOAD, RUN, DUMP_RD, DUMP_OUT; `start` ignored while busy.
- `cycle_count` saturates at 2^32-1.

## Timing
- Reset values: state IDLE, `ld_ready`=0, `dmp_valid`=0, `dmp_data`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0.
- Reset mid-run: all of the above at once; partial dump discarded, RAM contents untouched.
- Load: 1 word/cycle max; `start` → first `ld_ready` next cycle.
- RUN entered the cycle after the last load handshake; `cpu_reset` falls in that cycle.
- Dump: 2 cycles/word minimum; `dmp_valid` first rises 2 cycles after `cpu_ended` sampled.
- `dmp_valid` never drops without handshake; `dmp_data` constant while valid.

## Configuration
- `RUN_CTRL_WATCHDOG_EN` defined: in RUN, when `cycle_count` reaches `max_cycles` without `cpu_ended`, set `timeout`=1 and go to DUMP_RD; `timeout` holds until next `start` or reset. Same-cycle `cpu_ended` wins, `timeout` stays 0.
- Undefined: no watchdog, `timeout` tied 0, RUN waits for `cpu_ended` indefinitely.

## Test plan
- Load 13, 8; CPU model writes 104 to addr 2 and raises `cpu_ended` after 50 cycles → dump word 2 = 104, words 0/1 = 13/8, 32 words total, `cycle_count`=50, `done`=1.
- `ld_valid` toggled 1-0-1 and `dmp_ready` low 3 cycles per word → no lost/duplicated words, `dmp_data` stable while stalled.
- Watchdog on, `max_cycles`=20, `cpu_ended` never → `timeout`=1, `cycle_count`=20, full dump; macro off → stays in RUN after 100 cycles.
- `reset` low during RUN at cycle 10 → all outputs at reset values same cycle, `cpu_reset`=1; new `start` runs cleanly.
- `start` pulsed during LOAD and DUMP → ignored; `start` in DONE → second run, `cycle_count` restarts from 0.
